// File: rtl/frame_buffer_writer.sv
// frame_buffer_writer
// Takes a raster-ordered valid/ready stream of RGB pixels and writes it into
// a double-banked pixel RAM. The bank being filled is always the one the
// display is not reading. The displayed bank flips only on the display
// controller's frame-sync pulse, so a torn frame is never shown.
module frame_buffer_writer #(
  parameter int MATRIX_COLS = 64,
  parameter int MATRIX_ROWS = 32,
  parameter int PIXEL_BITS  = 24,
  localparam int N          = MATRIX_COLS * MATRIX_ROWS,
  localparam int ADDR_W     = $clog2(N)
) (
  input  logic                  i_clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [PIXEL_BITS-1:0] i_data,
  input  logic                  i_sof,
  output logic                  o_we,
  output logic [ADDR_W:0]       o_wr_addr,
  output logic [PIXEL_BITS-1:0] o_wr_data,
  input  logic                  i_frame_sync,
  output logic                  o_disp_bank,
  output logic                  o_frame_done,
  output logic                  o_err_sof
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    WAIT_SWAP = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(N - 1);

  state_t                  state_reg,      state_next;
  logic [ADDR_W-1:0]       pix_cnt_reg,    pix_cnt_next;
  logic                    disp_bank_reg,  disp_bank_next;
  logic                    we_reg,         we_next;
  logic [ADDR_W:0]         wr_addr_reg,    wr_addr_next;
  logic [PIXEL_BITS-1:0]   wr_data_reg,    wr_data_next;
  logic                    frame_done_reg, frame_done_next;
  logic                    err_sof_reg,    err_sof_next;

  logic wr_bank;
  logic xfer;

  // Ready depends only on the registered state: stalled only while the
  // finished frame waits for the display to take it.
  assign o_ready = (state_reg != WAIT_SWAP);
  assign xfer    = i_valid & o_ready;
  assign wr_bank = ~disp_bank_reg;

  // State and registered write-port outputs.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      pix_cnt_reg    <= '0;
      disp_bank_reg  <= 1'b1;
      we_reg         <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
      frame_done_reg <= 1'b0;
      err_sof_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pix_cnt_reg    <= pix_cnt_next;
      disp_bank_reg  <= disp_bank_next;
      we_reg         <= we_next;
      wr_addr_reg    <= wr_addr_next;
      wr_data_reg    <= wr_data_next;
      frame_done_reg <= frame_done_next;
      err_sof_reg    <= err_sof_next;
    end
  end

  // Next-state and write decisions; strobes default low, address/data hold.
  always_comb begin
    state_next      = state_reg;
    pix_cnt_next    = pix_cnt_reg;
    disp_bank_next  = disp_bank_reg;
    we_next         = 1'b0;
    wr_addr_next    = wr_addr_reg;
    wr_data_next    = wr_data_reg;
    frame_done_next = 1'b0;
    err_sof_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        // Pixels arriving before a start-of-frame are consumed and dropped.
        if (xfer && i_sof) begin
          we_next      = 1'b1;
          wr_addr_next = {wr_bank, {ADDR_W{1'b0}}};
          wr_data_next = i_data;
          pix_cnt_next = ADDR_W'(1);
          state_next   = WRITE;
        end
      end

      WRITE: begin
        if (xfer) begin
          we_next      = 1'b1;
          wr_data_next = i_data;
          if (i_sof) begin
            // Unexpected start-of-frame: abandon the partial frame and
            // restart at pixel 0 of the same bank. Takes priority over
            // the end-of-frame check.
            err_sof_next = 1'b1;
            wr_addr_next = {wr_bank, {ADDR_W{1'b0}}};
            pix_cnt_next = ADDR_W'(1);
          end else begin
            wr_addr_next = {wr_bank, pix_cnt_reg};
            if (pix_cnt_reg == LAST_PIX) begin
              frame_done_next = 1'b1;
              pix_cnt_next    = '0;
              state_next      = WAIT_SWAP;
            end else begin
              pix_cnt_next = pix_cnt_reg + ADDR_W'(1);
            end
          end
        end
      end

      WAIT_SWAP: begin
        // Only a sync pulse seen here swaps banks; earlier pulses are ignored.
        if (i_frame_sync) begin
          disp_bank_next = ~disp_bank_reg;
          state_next     = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign o_we         = we_reg;
  assign o_wr_addr    = wr_addr_reg;
  assign o_wr_data    = wr_data_reg;
  assign o_disp_bank  = disp_bank_reg;
  assign o_frame_done = frame_done_reg;
  assign o_err_sof    = err_sof_reg;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// tb_frame_buffer_writer
// Directed bench for frame_buffer_writer on a 4x2 panel (8 pixels/frame,
// 4-bit write address with the bank in bit 3).
module tb_frame_buffer_writer;

  localparam int COLS = 4;
  localparam int ROWS = 2;
  localparam int PB   = 24;

  logic          i_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [PB-1:0] i_data = '0;
  logic          i_sof = 1'b0;
  logic          o_we;
  logic [3:0]    o_wr_addr;
  logic [PB-1:0] o_wr_data;
  logic          i_frame_sync = 1'b0;
  logic          o_disp_bank;
  logic          o_frame_done;
  logic          o_err_sof;

  int checks = 0;
  int errors = 0;

  frame_buffer_writer #(
    .MATRIX_COLS(COLS),
    .MATRIX_ROWS(ROWS),
    .PIXEL_BITS (PB)
  ) dut (
    .i_clk       (i_clk),
    .rst_n       (rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_data      (i_data),
    .i_sof       (i_sof),
    .o_we        (o_we),
    .o_wr_addr   (o_wr_addr),
    .o_wr_data   (o_wr_data),
    .i_frame_sync(i_frame_sync),
    .o_disp_bank (o_disp_bank),
    .o_frame_done(o_frame_done),
    .o_err_sof   (o_err_sof)
  );

  always #5 i_clk = ~i_clk;

  // One line per RAM write transaction.
  always @(negedge i_clk) begin
    if (o_we)
      $display("WR addr=%0d data=%06h done=%0b err_sof=%0b bank=%0b",
               o_wr_addr, o_wr_data, o_frame_done, o_err_sof, o_disp_bank);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic tick(input logic v, input logic s, input logic fs, input logic [PB-1:0] d);
    i_valid      = v;
    i_sof        = s;
    i_frame_sync = fs;
    i_data       = d;
    @(posedge i_clk);
    #1;
    i_valid      = 1'b0;
    i_sof        = 1'b0;
    i_frame_sync = 1'b0;
  endtask

  task automatic exp_wr(input string tag, input logic [3:0] a, input logic [PB-1:0] d,
                        input logic fd, input logic es);
    chk({tag, "_we"},   32'(o_we), 32'd1);
    chk({tag, "_addr"}, 32'(o_wr_addr), 32'(a));
    chk({tag, "_data"}, 32'(o_wr_data), 32'(d));
    chk({tag, "_done"}, 32'(o_frame_done), 32'(fd));
    chk({tag, "_err"},  32'(o_err_sof), 32'(es));
  endtask

  task automatic exp_idle(input string tag);
    chk({tag, "_we"},   32'(o_we), 32'd0);
    chk({tag, "_done"}, 32'(o_frame_done), 32'd0);
  endtask

  initial begin
    // T1: reset held with valid/sof asserted
    rst_n = 1'b0;
    i_valid = 1'b1; i_sof = 1'b1; i_data = 24'h000055;
    repeat (3) @(posedge i_clk);
    #1;
    chk("t1_we",    32'(o_we), 32'd0);
    chk("t1_bank",  32'(o_disp_bank), 32'd1);
    chk("t1_addr",  32'(o_wr_addr), 32'd0);
    chk("t1_data",  32'(o_wr_data), 32'd0);
    chk("t1_done",  32'(o_frame_done), 32'd0);
    chk("t1_err",   32'(o_err_sof), 32'd0);
    i_valid = 1'b0; i_sof = 1'b0;
    rst_n = 1'b1;
    tick(1'b0, 1'b0, 1'b0, '0);
    chk("t1_ready", 32'(o_ready), 32'd1);
    exp_idle("t1_post");

    // T2: full frame into bank 0
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, (i == 0), 1'b0, PB'(i + 1));
      exp_wr("t2", 4'(i), PB'(i + 1), (i == 7), 1'b0);
    end
    chk("t2_ready", 32'(o_ready), 32'd0);
    chk("t2_bank",  32'(o_disp_bank), 32'd1);

    // T3: stalled 5 cycles (offered data must not be taken), then swap
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b1, 1'b0, 24'h123456);
      exp_idle("t3_hold");
      chk("t3_hold_ready", 32'(o_ready), 32'd0);
    end
    chk("t3_bank_pre", 32'(o_disp_bank), 32'd1);
    tick(1'b0, 1'b0, 1'b1, '0);
    chk("t3_bank",  32'(o_disp_bank), 32'd0);
    chk("t3_ready", 32'(o_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, (i == 0), 1'b0, PB'(24'h000100 + i));
      exp_wr("t3", 4'(8 + i), PB'(24'h000100 + i), (i == 7), 1'b0);
    end
    tick(1'b0, 1'b0, 1'b1, '0);
    chk("t3_bank_back", 32'(o_disp_bank), 32'd1);

    // T4: resync on a mid-frame sof, write bank 0
    tick(1'b1, 1'b1, 1'b0, 24'h000A00);
    exp_wr("t4_p0", 4'd0, 24'h000A00, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      tick(1'b1, 1'b0, 1'b0, PB'(24'h000A00 + i));
      exp_wr("t4_p", 4'(i), PB'(24'h000A00 + i), 1'b0, 1'b0);
    end
    tick(1'b1, 1'b1, 1'b0, 24'hABCDEF);
    exp_wr("t4_resync", 4'd0, 24'hABCDEF, 1'b0, 1'b1);
    chk("t4_bank", 32'(o_disp_bank), 32'd1);
    tick(1'b1, 1'b0, 1'b0, 24'h0B0001);
    exp_wr("t4_restart", 4'd1, 24'h0B0001, 1'b0, 1'b0);

    // T5: finish the frame with valid gaps; sync coincides with last xfer
    for (int i = 2; i < 8; i++) begin
      tick(1'b0, 1'b0, 1'b0, '0);
      exp_idle("t5_gap");
      if (i % 2 == 0) begin
        tick(1'b0, 1'b0, 1'b0, '0);
        exp_idle("t5_gap2");
      end
      tick(1'b1, 1'b0, (i == 7), PB'(24'h0B0000 + i));
      exp_wr("t5_p", 4'(i), PB'(24'h0B0000 + i), (i == 7), 1'b0);
    end
    chk("t5_nosync_bank", 32'(o_disp_bank), 32'd1);
    tick(1'b0, 1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, 1'b0, '0);
    chk("t5_wait_bank", 32'(o_disp_bank), 32'd1);
    tick(1'b0, 1'b0, 1'b1, '0);
    chk("t5_swap_bank", 32'(o_disp_bank), 32'd0);
    // Pixels without sof in IDLE are dropped
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 1'b0, PB'(24'hDEAD00 + i));
      exp_idle("t5_drop");
      chk("t5_drop_ready", 32'(o_ready), 32'd1);
    end

    // T6: reset mid-frame (write bank 1)
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, (i == 0), 1'b0, PB'(24'h0C0000 + i));
      exp_wr("t6_p", 4'(8 + i), PB'(24'h0C0000 + i), 1'b0, 1'b0);
    end
    i_valid = 1'b1; i_data = 24'h0C0004;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_we",   32'(o_we), 32'd0);
    chk("t6_rst_bank", 32'(o_disp_bank), 32'd1);
    chk("t6_rst_addr", 32'(o_wr_addr), 32'd0);
    chk("t6_rst_data", 32'(o_wr_data), 32'd0);
    @(posedge i_clk);
    #1;
    chk("t6_hold_we", 32'(o_we), 32'd0);
    i_valid = 1'b0;
    rst_n = 1'b1;
    tick(1'b1, 1'b1, 1'b0, 24'h0D0000);
    exp_wr("t6_new0", 4'd0, 24'h0D0000, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 24'h0D0001);
    exp_wr("t6_new1", 4'd1, 24'h0D0001, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
